// File: rtl/instr_r_tx.sv
// Read-back transmitter: serialises a 32-bit instruction word and its 32-bit
// address into bytes for the UART TX, LSB-first, data bytes first, then the
// address bytes when SEND_ADDR is set.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no transfer; waits for send_req while read-back mode is on
// SEND      | waits for the UART to be free, then presents the next byte
// WAIT_ACK  | byte request held until the UART reports busy (or time-out)
// WAIT_DONE | UART shifting the byte; advances to next byte when it ends
// DONE      | one-cycle completion pulse on done_tx
module instr_r_tx #(
    parameter int SEND_ADDR   = 1,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pos_instr_r,
    input  logic        neg_instr_r,
    input  logic        send_req,
    input  logic [31:0] data_tx,
    input  logic [31:0] addr_tx,
    input  logic        tx_busy,
    output logic [7:0]  data_out_tx,
    output logic        tx_data_valid,
    output logic        direct_tx,
    output logic        busy_tx,
    output logic        done_tx,
    output logic        err_tx
);

    localparam int NBYTES = (SEND_ADDR != 0) ? 8 : 4;
    localparam int TW     = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [2:0]    LAST_BYTE = 3'(NBYTES - 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEND      = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [2:0]    cnt;
    logic [2:0]    cnt_nxt;
    logic [63:0]   shadow;
    logic [63:0]   shadow_nxt;
    logic [TW-1:0] tmo;
    logic [TW-1:0] tmo_nxt;
    logic [7:0]    dout_nxt;
    logic          valid_nxt;
    logic          direct_nxt;
    logic          err_nxt;
    logic          done_nxt;
    logic          busy_nxt;

    logic abort;
    logic accept;
    logic ack_tmo;

    // A mode pulse during a transfer kills it, ahead of any other transition.
    assign abort   = (pos_instr_r | neg_instr_r) & (state != S_IDLE);
    assign accept  = (state == S_IDLE) & direct_tx & send_req;
    assign ack_tmo = (tmo == TMO_MAX);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = S_SEND;
            end
            S_SEND: begin
                if (!tx_busy) state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (tx_busy)      state_nxt = S_WAIT_DONE;
                else if (ack_tmo) state_nxt = S_IDLE;
            end
            S_WAIT_DONE: begin
                if (!tx_busy) state_nxt = (cnt == LAST_BYTE) ? S_DONE : S_SEND;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    // Next values of the datapath and of every registered output
    always_comb begin
        cnt_nxt    = cnt;
        shadow_nxt = shadow;
        tmo_nxt    = tmo;
        dout_nxt   = data_out_tx;
        valid_nxt  = tx_data_valid;
        err_nxt    = err_tx;

        if (pos_instr_r)      direct_nxt = 1'b1;
        else if (neg_instr_r) direct_nxt = 1'b0;
        else                  direct_nxt = direct_tx;

        if (abort) begin
            // data_out_tx and err_tx deliberately keep their values.
            valid_nxt = 1'b0;
            cnt_nxt   = 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        shadow_nxt = {addr_tx, data_tx};
                        cnt_nxt    = 3'd0;
                        err_nxt    = 1'b0;
                    end
                end
                S_SEND: begin
                    if (!tx_busy) begin
                        dout_nxt  = shadow[{cnt, 3'b000} +: 8];
                        valid_nxt = 1'b1;
                        tmo_nxt   = '0;
                    end
                end
                S_WAIT_ACK: begin
                    if (tx_busy) begin
                        valid_nxt = 1'b0;
                    end else if (ack_tmo) begin
                        valid_nxt = 1'b0;
                        err_nxt   = 1'b1;
                    end else begin
                        tmo_nxt = tmo + TW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy && (cnt != LAST_BYTE)) cnt_nxt = cnt + 3'd1;
                end
                default: begin
                end
            endcase
        end

        done_nxt = (state_nxt == S_DONE);
        busy_nxt = (state_nxt != S_IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt           <= 3'd0;
            shadow        <= 64'd0;
            tmo           <= '0;
            data_out_tx   <= 8'd0;
            tx_data_valid <= 1'b0;
            direct_tx     <= 1'b0;
            busy_tx       <= 1'b0;
            done_tx       <= 1'b0;
            err_tx        <= 1'b0;
        end else begin
            cnt           <= cnt_nxt;
            shadow        <= shadow_nxt;
            tmo           <= tmo_nxt;
            data_out_tx   <= dout_nxt;
            tx_data_valid <= valid_nxt;
            direct_tx     <= direct_nxt;
            busy_tx       <= busy_nxt;
            done_tx       <= done_nxt;
            err_tx        <= err_nxt;
        end
    end

endmodule

// File: tb/tb_instr_r_tx.sv
// Bench for instr_r_tx: two instances (8-byte with default time-out, 4-byte
// with a 15-cycle time-out), each driven against a simple UART TX model.
module tb_instr_r_tx;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    logic        pos_r  [2];
    logic        neg_r  [2];
    logic        send_r [2];
    logic [31:0] dat    [2];
    logic [31:0] adr    [2];
    logic        tx_busy[2];
    logic [7:0]  dout   [2];
    logic        valid  [2];
    logic        direct [2];
    logic        busy   [2];
    logic        done   [2];
    logic        err    [2];

    instr_r_tx #(.SEND_ADDR(1)) u_dut8 (
        .clk(clk), .rst(rst),
        .pos_instr_r(pos_r[0]), .neg_instr_r(neg_r[0]), .send_req(send_r[0]),
        .data_tx(dat[0]), .addr_tx(adr[0]), .tx_busy(tx_busy[0]),
        .data_out_tx(dout[0]), .tx_data_valid(valid[0]), .direct_tx(direct[0]),
        .busy_tx(busy[0]), .done_tx(done[0]), .err_tx(err[0])
    );

    instr_r_tx #(.SEND_ADDR(0), .ACK_TIMEOUT(15)) u_dut4 (
        .clk(clk), .rst(rst),
        .pos_instr_r(pos_r[1]), .neg_instr_r(neg_r[1]), .send_req(send_r[1]),
        .data_tx(dat[1]), .addr_tx(adr[1]), .tx_busy(tx_busy[1]),
        .data_out_tx(dout[1]), .tx_data_valid(valid[1]), .direct_tx(direct[1]),
        .busy_tx(busy[1]), .done_tx(done[1]), .err_tx(err[1])
    );

    // UART TX model: takes a byte on a rising request, then stays busy busy_len cycles
    logic       uart_en  [2];
    int         busy_len [2];
    int         busy_left[2];
    logic       prev_v   [2];
    logic [7:0] got_q    [2][$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                tx_busy[k]   <= 1'b0;
                busy_left[k] <= 0;
                prev_v[k]    <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                prev_v[k] <= valid[k];
                if (busy_left[k] > 1) begin
                    busy_left[k] <= busy_left[k] - 1;
                end else if (busy_left[k] == 1) begin
                    busy_left[k] <= 0;
                    tx_busy[k]   <= 1'b0;
                end else if (uart_en[k] && valid[k] && !prev_v[k]) begin
                    got_q[k].push_back(dout[k]);
                    busy_left[k] <= busy_len[k];
                    tx_busy[k]   <= 1'b1;
                end
            end
        end
    end

    // Monitor: counts done pulses and measures how long each byte request stays high
    int done_cnt[2];
    int vrun[2];
    int vlast[2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (done[k] === 1'b1) done_cnt[k] <= done_cnt[k] + 1;
            if (valid[k] === 1'b1) begin
                vrun[k] <= vrun[k] + 1;
            end else if (vrun[k] > 0) begin
                vlast[k] <= vrun[k];
                vrun[k]  <= 0;
            end
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // which: 0 pos_instr_r, 1 neg_instr_r, 2 send_req, 3 pos+neg together
    task automatic pulse(input int k, input int which);
        @(negedge clk);
        case (which)
            0:       pos_r[k] = 1'b1;
            1:       neg_r[k] = 1'b1;
            2:       send_r[k] = 1'b1;
            default: begin pos_r[k] = 1'b1; neg_r[k] = 1'b1; end
        endcase
        @(negedge clk);
        pos_r[k]  = 1'b0;
        neg_r[k]  = 1'b0;
        send_r[k] = 1'b0;
    endtask

    task automatic wait_bytes(input int k, input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            if (got_q[k].size() >= n) ok = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string tag, input int k);
        check_eq(tag, {dout[k], valid[k], direct[k], busy[k], done[k], err[k]}, 64'd0);
    endtask

    // One full transfer, compared against the byte list implied by {addr, data}
    task automatic run_xfer(input int k, input logic [31:0] data, input logic [31:0] addr,
                            input int blen, input bit mid_req);
        int          base;
        int          d0;
        int          nb;
        bit          seen;
        bit          ok;
        logic [63:0] word;
        logic [7:0]  exp_b;
        nb          = (k == 0) ? 8 : 4;
        busy_len[k] = blen;
        uart_en[k]  = 1'b1;
        base        = got_q[k].size();
        d0          = done_cnt[k];
        dat[k]      = data;
        adr[k]      = addr;
        pulse(k, 2);
        check_eq("accept_busy", {63'd0, busy[k]}, 64'd1);
        check_eq("accept_err_clr", {63'd0, err[k]}, 64'd0);
        dat[k] = $urandom;
        adr[k] = $urandom;
        if (mid_req) begin
            wait_bytes(k, base + 2, ok);
            check_eq("mid_wait", {63'd0, ok}, 64'd1);
            pulse(k, 2);
        end
        seen = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clk);
            if (done[k] === 1'b1) seen = 1'b1;
        end
        check_eq("done_seen", {63'd0, seen}, 64'd1);
        @(negedge clk);
        check_eq("done_one_cycle", {63'd0, done[k]}, 64'd0);
        check_eq("busy_low_after", {63'd0, busy[k]}, 64'd0);
        check_eq("done_count", 64'(done_cnt[k] - d0), 64'd1);
        check_eq("byte_count", 64'(got_q[k].size() - base), 64'(nb));
        word = {addr, data};
        for (int i = 0; i < nb; i++) begin
            if (base + i < got_q[k].size()) begin
                exp_b = 8'((word >> (8 * i)) & 64'hFF);
                check_eq($sformatf("ch%0d_byte%0d", k, i), {56'd0, got_q[k][base + i]}, {56'd0, exp_b});
            end
        end
    endtask

    initial begin
        int          base;
        int          d0;
        bit          ok;
        logic [63:0] word;

        for (int k = 0; k < 2; k++) begin
            pos_r[k]    = 1'b0;
            neg_r[k]    = 1'b0;
            send_r[k]   = 1'b0;
            dat[k]      = 32'd0;
            adr[k]      = 32'd0;
            uart_en[k]  = 1'b1;
            busy_len[k] = 10;
        end

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_ch0", 0);
        check_reset_outputs("reset_ch1", 1);

        // Mode control: pos sets, neg clears, pos wins when both arrive together
        pulse(0, 0);
        pulse(1, 0);
        check_eq("direct_on_ch0", {63'd0, direct[0]}, 64'd1);
        check_eq("direct_on_ch1", {63'd0, direct[1]}, 64'd1);
        pulse(1, 1);
        check_eq("direct_off", {63'd0, direct[1]}, 64'd0);
        pulse(1, 3);
        check_eq("direct_both", {63'd0, direct[1]}, 64'd1);

        // Fixed vectors: 8-byte and 4-byte streams
        run_xfer(0, 32'h12345678, 32'h0000_0040, 10, 1'b0);
        run_xfer(1, 32'hDEADBEEF, 32'h0000_0000, 10, 1'b0);

        // A second send_req mid-transfer must not disturb the byte stream
        run_xfer(0, 32'hCAFEF00D, 32'h0000_1000, 10, 1'b1);
        run_xfer(1, 32'hA5C3_1E7F, 32'h0, 4, 1'b1);

        // send_req while read-back mode is off is ignored
        pulse(1, 1);
        base = got_q[1].size();
        dat[1] = 32'h1111_2222;
        pulse(1, 2);
        repeat (20) @(negedge clk);
        check_eq("off_busy", {63'd0, busy[1]}, 64'd0);
        check_eq("off_valid", {63'd0, valid[1]}, 64'd0);
        check_eq("off_bytes", 64'(got_q[1].size() - base), 64'd0);
        pulse(1, 0);

        // Ack time-out: UART never responds, request held ACK_TIMEOUT+1 cycles
        uart_en[1] = 1'b0;
        d0 = done_cnt[1];
        dat[1] = 32'h0BAD_F00D;
        pulse(1, 2);
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (valid[1] === 1'b1) ok = 1'b1;
        end
        check_eq("tmo_valid_rise", {63'd0, ok}, 64'd1);
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (valid[1] === 1'b0) ok = 1'b1;
        end
        check_eq("tmo_valid_fall", {63'd0, ok}, 64'd1);
        @(negedge clk);
        check_eq("tmo_valid_len", 64'(vlast[1]), 64'd16);
        check_eq("tmo_err", {63'd0, err[1]}, 64'd1);
        check_eq("tmo_busy", {63'd0, busy[1]}, 64'd0);
        repeat (5) @(negedge clk);
        check_eq("tmo_err_sticky", {63'd0, err[1]}, 64'd1);
        check_eq("tmo_no_done", 64'(done_cnt[1] - d0), 64'd0);
        run_xfer(1, 32'h7654_3210, 32'h0, 3, 1'b0);

        // Abort after the third byte via neg_instr_r
        busy_len[0] = 10;
        base = got_q[0].size();
        d0   = done_cnt[0];
        word = {32'h0000_0080, 32'h9ABC_DEF0};
        dat[0] = word[31:0];
        adr[0] = word[63:32];
        pulse(0, 2);
        wait_bytes(0, base + 3, ok);
        check_eq("abort_wait", {63'd0, ok}, 64'd1);
        pulse(0, 1);
        check_eq("abort_valid", {63'd0, valid[0]}, 64'd0);
        check_eq("abort_direct", {63'd0, direct[0]}, 64'd0);
        check_eq("abort_busy", {63'd0, busy[0]}, 64'd0);
        check_eq("abort_dout_hold", {56'd0, dout[0]}, (word >> 16) & 64'hFF);
        repeat (40) @(negedge clk);
        check_eq("abort_no_more_bytes", 64'(got_q[0].size() - base), 64'd3);
        check_eq("abort_no_done", 64'(done_cnt[0] - d0), 64'd0);
        pulse(0, 0);

        // Randomised transfers on both channels
        for (int n = 0; n < 8; n++) begin
            run_xfer(n % 2, $urandom, $urandom, $urandom_range(1, 12), n[2]);
        end

        // Asynchronous reset in the middle of a transfer
        base = got_q[0].size();
        dat[0] = 32'h5555_AAAA;
        pulse(0, 2);
        wait_bytes(0, base + 1, ok);
        check_eq("rst_mid_wait", {63'd0, ok}, 64'd1);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("rst_async_ch0", 0);
        check_reset_outputs("rst_async_ch1", 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_after_busy", {63'd0, busy[0]}, 64'd0);
        check_eq("rst_after_valid", {63'd0, valid[0]}, 64'd0);
        pulse(0, 0);
        run_xfer(0, 32'h0F1E_2D3C, 32'h4B5A_6978, 5, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
